cajero_param: RTL

- Parametrised ATM transaction controller; next generation of the fixed 4-digit, 3-attempt cajero.
- Accepts a card, collects a PIN digit-by-digit, verifies it and enforces an attempt limit with warning and lockout.
- Executes one deposit or withdrawal per session against a latched balance, with an added per-transaction withdrawal limit.
- Sits between the keypad/card front-end (strobed inputs) and the dispenser/ledger logic (pulsed outputs).

---
 rtl/cajero_param.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cajero_param.sv
`default_nettype none
// ============================================================================
// Module   : cajero_param
// Brief    : Parametrised ATM session controller: card, PIN entry with attempt
//            lockout, one deposit/withdrawal per session against a latched
//            balance. Define CAJERO_TIMEOUT_EN for the inactivity timeout.
// Revision : 1.0 - initial release
// ============================================================================
module cajero_param #(
  parameter int              PIN_DIGITS     = 4,
  parameter int              MAX_INTENTOS   = 3,
  parameter int              MONTO_W        = 32,
  parameter int              BALANCE_W      = 64,
  parameter longint unsigned LIMITE_RETIRO  = 100000,
  parameter int              TIMEOUT_CICLOS = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_tarjeta_recibida,
  input  logic                    i_tipo_trans,
  input  logic [4*PIN_DIGITS-1:0] i_pin,
  input  logic [3:0]              i_digito,
  input  logic                    i_digito_stb,
  input  logic [MONTO_W-1:0]      i_monto,
  input  logic                    i_monto_stb,
  input  logic [BALANCE_W-1:0]    i_balance_inicial,
  output logic [BALANCE_W-1:0]    o_balance,
  output logic                    o_balance_actualizado,
  output logic                    o_entregar_dinero,
  output logic                    o_pin_incorrecto,
  output logic                    o_advertencia,
  output logic                    o_bloqueo,
  output logic                    o_fondos_insuficientes,
  output logic                    o_limite_excedido,
  output logic                    o_tiempo_agotado
);

  localparam int                   c_pin_w   = 4 * PIN_DIGITS;
  localparam int                   c_cnt_w   = $clog2(PIN_DIGITS + 1);
  localparam logic [c_cnt_w-1:0]   c_cnt_fin = c_cnt_w'(PIN_DIGITS);
  localparam logic [3:0]           c_max     = 4'(MAX_INTENTOS);
  localparam logic [3:0]           c_warn    = 4'(MAX_INTENTOS - 1);
  localparam logic [BALANCE_W-1:0] c_limite  = BALANCE_W'(LIMITE_RETIRO);

  typedef enum logic [2:0] {
    ESPERA       = 3'd0,
    INGRESO_PIN  = 3'd1,
    VERIFICA     = 3'd2,
    ESPERA_MONTO = 3'd3,
    PROCESA      = 3'd4,
    BLOQUEADO    = 3'd5
  } state_t;

  state_t                 r_state, w_state_next;
  logic                   r_digito_stb_d, r_monto_stb_d;
  logic [c_pin_w-1:0]     r_pin, w_pin_next;
  logic [c_pin_w-1:0]     r_shift, w_shift_next;
  logic [c_cnt_w-1:0]     r_cnt, w_cnt_next;
  logic [3:0]             r_intentos, w_intentos_next;
  logic                   r_advertencia, w_advertencia_next;
  logic                   r_bloqueo, w_bloqueo_next;
  logic [BALANCE_W-1:0]   r_balance, w_balance_next;
  logic [BALANCE_W-1:0]   r_monto, w_monto_next;
  logic                   r_tipo, w_tipo_next;
  logic                   r_actualizado, w_actualizado_next;
  logic                   r_entregar, w_entregar_next;
  logic                   r_pin_inc, w_pin_inc_next;
  logic                   r_fondos, w_fondos_next;
  logic                   r_limite, w_limite_next;

  logic                   w_digito_edge, w_monto_edge;
  logic [c_cnt_w-1:0]     w_cnt_inc;
  logic [3:0]             w_intentos_inc;
  logic [BALANCE_W:0]     w_suma;

`ifdef CAJERO_TIMEOUT_EN
  localparam int                 c_inact_w   = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [c_inact_w-1:0] c_inact_fin = c_inact_w'(TIMEOUT_CICLOS - 1);
  logic [c_inact_w-1:0]   r_inact, w_inact_next;
  logic                   r_tiempo, w_tiempo_next;
`endif

  assign w_digito_edge  = i_digito_stb & ~r_digito_stb_d;
  assign w_monto_edge   = i_monto_stb & ~r_monto_stb_d;
  assign w_cnt_inc      = r_cnt + c_cnt_w'(1);
  assign w_intentos_inc = r_intentos + 4'd1;
  assign w_suma         = {1'b0, r_balance} + {1'b0, r_monto};

  always_comb begin
    w_state_next       = r_state;
    w_pin_next         = r_pin;
    w_shift_next       = r_shift;
    w_cnt_next         = r_cnt;
    w_intentos_next    = r_intentos;
    w_advertencia_next = r_advertencia;
    w_bloqueo_next     = r_bloqueo;
    w_balance_next     = r_balance;
    w_monto_next       = r_monto;
    w_tipo_next        = r_tipo;
    w_actualizado_next = 1'b0;
    w_entregar_next    = 1'b0;
    w_pin_inc_next     = 1'b0;
    w_fondos_next      = 1'b0;
    w_limite_next      = 1'b0;
`ifdef CAJERO_TIMEOUT_EN
    w_inact_next       = '0;
    w_tiempo_next      = 1'b0;
`endif

    case (r_state)
      ESPERA: begin
        if (i_tarjeta_recibida) begin
          w_state_next   = INGRESO_PIN;
          w_pin_next     = i_pin;
          w_balance_next = i_balance_inicial;
          w_cnt_next     = '0;
          w_shift_next   = '0;
        end
      end
      INGRESO_PIN: begin
        if (!i_tarjeta_recibida) begin
          w_state_next = ESPERA;
        end else if (w_digito_edge) begin
          w_shift_next = c_pin_w'({r_shift, i_digito});
          w_cnt_next   = w_cnt_inc;
          if (w_cnt_inc == c_cnt_fin) w_state_next = VERIFICA;
        end
      end
      VERIFICA: begin
        if (r_shift == r_pin) begin
          w_state_next       = ESPERA_MONTO;
          w_intentos_next    = '0;
          w_advertencia_next = 1'b0;
        end else begin
          w_pin_inc_next  = 1'b1;
          w_intentos_next = w_intentos_inc;
          w_cnt_next      = '0;
          if (w_intentos_inc == c_max) begin
            w_state_next       = BLOQUEADO;
            w_bloqueo_next     = 1'b1;
            w_advertencia_next = 1'b0;
          end else begin
            w_state_next = INGRESO_PIN;
            if (w_intentos_inc == c_warn) w_advertencia_next = 1'b1;
          end
        end
      end
      ESPERA_MONTO: begin
        if (!i_tarjeta_recibida) begin
          w_state_next = ESPERA;
        end else if (w_monto_edge) begin
          w_state_next = PROCESA;
          w_monto_next = BALANCE_W'(i_monto);
          w_tipo_next  = i_tipo_trans;
        end
      end
      PROCESA: begin
        w_state_next = ESPERA;
        if (!r_tipo) begin
          // Deposit saturates instead of wrapping on carry-out.
          w_balance_next     = w_suma[BALANCE_W] ? '1 : w_suma[BALANCE_W-1:0];
          w_actualizado_next = 1'b1;
        end else if (r_monto > r_balance) begin
          w_fondos_next = 1'b1;
        end else if (r_monto > c_limite) begin
          w_limite_next = 1'b1;
        end else begin
          w_balance_next     = r_balance - r_monto;
          w_actualizado_next = 1'b1;
          w_entregar_next    = 1'b1;
        end
      end
      BLOQUEADO: ;
      default: w_state_next = ESPERA;
    endcase

`ifdef CAJERO_TIMEOUT_EN
    // Idle only counts while waiting on the user inside one collecting state.
    if ((r_state == INGRESO_PIN || r_state == ESPERA_MONTO) &&
        (w_state_next == r_state) && !w_digito_edge && !w_monto_edge) begin
      if (r_inact == c_inact_fin) begin
        w_state_next  = ESPERA;
        w_tiempo_next = 1'b1;
        w_cnt_next    = '0;
        w_shift_next  = '0;
      end else begin
        w_inact_next = r_inact + c_inact_w'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ESPERA;
      r_digito_stb_d <= 1'b0;
      r_monto_stb_d  <= 1'b0;
      r_pin          <= '0;
      r_shift        <= '0;
      r_cnt          <= '0;
      r_intentos     <= '0;
      r_advertencia  <= 1'b0;
      r_bloqueo      <= 1'b0;
      r_balance      <= '0;
      r_monto        <= '0;
      r_tipo         <= 1'b0;
      r_actualizado  <= 1'b0;
      r_entregar     <= 1'b0;
      r_pin_inc      <= 1'b0;
      r_fondos       <= 1'b0;
      r_limite       <= 1'b0;
`ifdef CAJERO_TIMEOUT_EN
      r_inact        <= '0;
      r_tiempo       <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_next;
      r_digito_stb_d <= i_digito_stb;
      r_monto_stb_d  <= i_monto_stb;
      r_pin          <= w_pin_next;
      r_shift        <= w_shift_next;
      r_cnt          <= w_cnt_next;
      r_intentos     <= w_intentos_next;
      r_advertencia  <= w_advertencia_next;
      r_bloqueo      <= w_bloqueo_next;
      r_balance      <= w_balance_next;
      r_monto        <= w_monto_next;
      r_tipo         <= w_tipo_next;
      r_actualizado  <= w_actualizado_next;
      r_entregar     <= w_entregar_next;
      r_pin_inc      <= w_pin_inc_next;
      r_fondos       <= w_fondos_next;
      r_limite       <= w_limite_next;
`ifdef CAJERO_TIMEOUT_EN
      r_inact        <= w_inact_next;
      r_tiempo       <= w_tiempo_next;
`endif
    end
  end

  assign o_balance              = r_balance;
  assign o_balance_actualizado  = r_actualizado;
  assign o_entregar_dinero      = r_entregar;
  assign o_pin_incorrecto       = r_pin_inc;
  assign o_advertencia          = r_advertencia;
  assign o_bloqueo              = r_bloqueo;
  assign o_fondos_insuficientes = r_fondos;
  assign o_limite_excedido      = r_limite;
`ifdef CAJERO_TIMEOUT_EN
  assign o_tiempo_agotado       = r_tiempo;
`else
  assign o_tiempo_agotado       = 1'b0;
`endif

endmodule
`default_nettype wire
